// File: rtl/seq_counter_pkg.sv
// Shared FSM state encoding and count-direction constants for seq_counter.
// Declarations only, no logic.
package seq_counter_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_e;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/seq_counter_step.sv
// Next-count and terminal-count logic: +/-1 modulo 2^WIDTH, wrap or hold at terminal.
// Purely combinational, zero latency, no flow control.
module seq_counter_step
   import seq_counter_pkg::*;
#(
   parameter int WIDTH    = 5,
   parameter int LIMIT    = 31,
   parameter int SATURATE = 0
) (
   input  logic [WIDTH-1:0] i_count,
   input  logic             i_dir,
   output logic [WIDTH-1:0] o_count_nxt,
   output logic             o_tc
);

   localparam logic [WIDTH-1:0] L_TERM = WIDTH'(LIMIT);

   logic w_tc;

   assign w_tc = (i_dir == DIR_DOWN) ? (i_count == '0) : (i_count == L_TERM);
   assign o_tc = w_tc;

   // Terminal handling only matters in free-run; the sequencer never steps at terminal.
   always_comb begin
      o_count_nxt = i_count;
      if (w_tc && (SATURATE != 0)) begin
         o_count_nxt = i_count;
      end else if (w_tc) begin
         o_count_nxt = (i_dir == DIR_DOWN) ? L_TERM : '0;
      end else if (i_dir == DIR_DOWN) begin
         o_count_nxt = i_count - 1'b1;
      end else begin
         o_count_nxt = i_count + 1'b1;
      end
   end

endmodule

// File: rtl/seq_counter.sv
// Up/down counter with load, wrap/saturate and optional start/busy/done sequencer.
// count/busy/done registered (one edge), tc combinational; stalls only via i_en.
module seq_counter
   import seq_counter_pkg::*;
#(
   parameter int WIDTH    = 5,
   parameter int LIMIT    = 31,
   parameter int SEQ      = 1,
   parameter int SATURATE = 0
) (
   input  logic             i_clk,
   input  logic             i_clr_n,
   input  logic             i_en,
   input  logic             i_dir,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_start,
   output logic [WIDTH-1:0] o_count,
   output logic             o_tc,
   output logic             o_busy,
   output logic             o_done
);

   localparam logic [WIDTH-1:0] L_TERM = WIDTH'(LIMIT);

   state_e           r_state;
   state_e           w_state_nxt;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_count_nxt;
   logic [WIDTH-1:0] w_step_nxt;
   logic             w_tc;
   logic             w_start;

   seq_counter_step #(
      .WIDTH   (WIDTH),
      .LIMIT   (LIMIT),
      .SATURATE(SATURATE)
   ) u_step (
      .i_count    (r_count),
      .i_dir      (i_dir),
      .o_count_nxt(w_step_nxt),
      .o_tc       (w_tc)
   );

   // load outranks start on the same edge
   assign w_start = (SEQ != 0) && i_start && !i_load;

   always_ff @(posedge i_clk or negedge i_clr_n) begin
      if (!i_clr_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (SEQ != 0) begin
         case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_RUN;
            S_RUN:   if (!i_load && !w_start && i_en && w_tc) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = w_start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end else begin
         w_state_nxt = S_IDLE;
      end
   end

   always_comb begin
      o_busy = 1'b0;
      o_done = 1'b0;
      if (SEQ != 0) begin
         o_busy = (r_state == S_RUN);
         o_done = (r_state == S_DONE);
      end
   end

   // In RUN the terminal edge holds the count; the FSM moves to DONE instead.
   always_comb begin
      w_count_nxt = r_count;
      if (i_load) begin
         w_count_nxt = i_load_val;
      end else if (SEQ != 0) begin
         if (w_start) begin
            w_count_nxt = (i_dir == DIR_UP) ? '0 : L_TERM;
         end else if ((r_state == S_RUN) && i_en && !w_tc) begin
            w_count_nxt = w_step_nxt;
         end
      end else if (i_en) begin
         w_count_nxt = w_step_nxt;
      end
   end

   always_ff @(posedge i_clk or negedge i_clr_n) begin
      if (!i_clr_n) begin
         r_count <= '0;
      end else begin
         r_count <= w_count_nxt;
      end
   end

   assign o_count = r_count;
   assign o_tc    = w_tc;

endmodule

// File: tb/tb_seq_counter.sv
// Directed bench: sequenced default instance plus free-run wrap and saturate instances.
module tb_seq_counter;

   logic       clk;
   logic       clr_n;
   logic       en;
   logic       dir;
   logic       load;
   logic [4:0] load_val;
   logic       start;

   logic [4:0] s_count, b_count, c_count;
   logic       s_tc, s_busy, s_done;
   logic       b_tc, b_busy, b_done;
   logic       c_tc, c_busy, c_done;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic       load;
      logic [4:0] lv;
      logic       start;
      logic       en;
      logic       dir;
      logic [4:0] c;
      logic       tc;
      logic       busy;
      logic       done;
   } vec_t;

   vec_t tbl[$];

   seq_counter u_seq (
      .i_clk(clk), .i_clr_n(clr_n), .i_en(en), .i_dir(dir), .i_load(load),
      .i_load_val(load_val), .i_start(start),
      .o_count(s_count), .o_tc(s_tc), .o_busy(s_busy), .o_done(s_done)
   );

   seq_counter #(.WIDTH(5), .LIMIT(31), .SEQ(0), .SATURATE(0)) u_wrap (
      .i_clk(clk), .i_clr_n(clr_n), .i_en(en), .i_dir(dir), .i_load(load),
      .i_load_val(load_val), .i_start(start),
      .o_count(b_count), .o_tc(b_tc), .o_busy(b_busy), .o_done(b_done)
   );

   seq_counter #(.WIDTH(5), .LIMIT(9), .SEQ(0), .SATURATE(1)) u_sat (
      .i_clk(clk), .i_clr_n(clr_n), .i_en(en), .i_dir(dir), .i_load(load),
      .i_load_val(load_val), .i_start(start),
      .o_count(c_count), .o_tc(c_tc), .o_busy(c_busy), .o_done(c_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input int ld, input int lv, input int st, input int e, input int d,
                      input int c, input int tc, input int bz, input int dn);
      vec_t v;
      v.load  = ld[0];
      v.lv    = lv[4:0];
      v.start = st[0];
      v.en    = e[0];
      v.dir   = d[0];
      v.c     = c[4:0];
      v.tc    = tc[0];
      v.busy  = bz[0];
      v.done  = dn[0];
      tbl.push_back(v);
   endtask

   initial begin
      int cyc;
      int seen;

      clr_n = 1'b0; en = 1'b1; dir = 1'b1; load = 1'b0; load_val = '0; start = 1'b0;

      // reset held for three edges with en active
      repeat (3) step();
      chk("rst_count", 32'(s_count), 0);
      chk("rst_busy",  32'(s_busy), 0);
      chk("rst_done",  32'(s_done), 0);
      chk("rst_tc_down", 32'(s_tc), 1);
      chk("rst_wrap_count", 32'(b_count), 0);
      dir = 1'b0;
      #1;
      chk("rst_tc_up", 32'(s_tc), 0);
      clr_n = 1'b1;

      // free-run wrap, up, 40 edges
      for (int i = 1; i <= 40; i++) begin
         step();
         chk($sformatf("wrap_count[%0d]", i), 32'(b_count), i % 32);
         chk($sformatf("wrap_tc[%0d]", i), 32'(b_tc), ((i % 32) == 31) ? 1 : 0);
      end
      chk("freerun_busy", 32'(b_busy), 0);
      chk("seq_idle_ignores_en", 32'(s_count), 0);
      chk("seq_idle_busy", 32'(s_busy), 0);

      // saturate down from 3 (LIMIT 9) and wrap down from 3 (LIMIT 31)
      en = 1'b0; dir = 1'b1; load = 1'b1; load_val = 5'd3;
      step();
      load = 1'b0; en = 1'b1;
      chk("sat_load", 32'(c_count), 3);
      begin
         int exp_c[5] = '{2, 1, 0, 0, 0};
         int exp_b[5] = '{2, 1, 0, 31, 30};
         for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("sat_count[%0d]", i), 32'(c_count), exp_c[i]);
            chk($sformatf("sat_tc[%0d]", i), 32'(c_tc), (exp_c[i] == 0) ? 1 : 0);
            chk($sformatf("wrapdn_count[%0d]", i), 32'(b_count), exp_b[i]);
         end
      end
      chk("sat_done", 32'(c_done), 0);

      // loaded above LIMIT: steps wrap at 2^WIDTH, not at LIMIT
      en = 1'b0; dir = 1'b0; load = 1'b1; load_val = 5'd30;
      step();
      load = 1'b0; en = 1'b1;
      begin
         int exp_o[3] = '{31, 0, 1};
         for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("over_limit[%0d]", i), 32'(c_count), exp_o[i]);
         end
      end

      // sequencer table: load, lv, start, en, dir -> count, tc, busy, done
      add(1,  7, 0, 1, 0,   7, 0, 0, 0);
      add(0,  0, 0, 1, 0,   7, 0, 0, 0);
      add(0,  0, 1, 1, 0,   0, 0, 1, 0);
      add(0,  0, 0, 1, 0,   1, 0, 1, 0);
      add(0,  0, 0, 0, 0,   1, 0, 1, 0);
      add(1, 29, 0, 1, 0,  29, 0, 1, 0);
      add(0,  0, 0, 1, 0,  30, 0, 1, 0);
      add(0,  0, 0, 1, 0,  31, 1, 1, 0);
      add(0,  0, 0, 0, 0,  31, 1, 1, 0);
      add(0,  0, 0, 1, 0,  31, 1, 0, 1);
      add(0,  0, 0, 1, 0,  31, 1, 0, 0);
      add(0,  0, 1, 1, 1,  31, 0, 1, 0);
      add(0,  0, 0, 1, 1,  30, 0, 1, 0);
      add(1,  1, 0, 1, 1,   1, 0, 1, 0);
      add(0,  0, 0, 1, 1,   0, 1, 1, 0);
      add(0,  0, 0, 1, 1,   0, 1, 0, 1);
      add(0,  0, 1, 1, 0,   0, 0, 1, 0);
      add(0,  0, 0, 1, 0,   1, 0, 1, 0);
      add(0,  0, 0, 1, 1,   0, 1, 1, 0);
      add(0,  0, 0, 1, 1,   0, 1, 0, 1);
      add(1,  5, 1, 1, 0,   5, 0, 0, 0);
      add(1,  9, 1, 1, 0,   9, 0, 0, 0);
      add(0,  0, 0, 1, 0,   9, 0, 0, 0);
      foreach (tbl[i]) begin
         load = tbl[i].load; load_val = tbl[i].lv; start = tbl[i].start;
         en = tbl[i].en; dir = tbl[i].dir;
         step();
         chk($sformatf("tbl_count[%0d]", i), 32'(s_count), 32'(tbl[i].c));
         chk($sformatf("tbl_tc[%0d]", i),    32'(s_tc),    32'(tbl[i].tc));
         chk($sformatf("tbl_busy[%0d]", i),  32'(s_busy),  32'(tbl[i].busy));
         chk($sformatf("tbl_done[%0d]", i),  32'(s_done),  32'(tbl[i].done));
      end
      load = 1'b0; start = 1'b0; en = 1'b1; dir = 1'b0;

      // full default sequence
      start = 1'b1;
      step();
      start = 1'b0;
      chk("seq_e0_count", 32'(s_count), 0);
      chk("seq_e0_busy", 32'(s_busy), 1);
      for (int k = 1; k <= 31; k++) begin
         step();
         chk($sformatf("seq_count[%0d]", k), 32'(s_count), k);
         chk($sformatf("seq_busy[%0d]", k), 32'(s_busy), 1);
         chk($sformatf("seq_done[%0d]", k), 32'(s_done), 0);
      end
      step();
      chk("seq_e32_done", 32'(s_done), 1);
      chk("seq_e32_busy", 32'(s_busy), 0);
      chk("seq_e32_count", 32'(s_count), 31);
      step();
      chk("seq_e33_done", 32'(s_done), 0);
      chk("seq_e33_busy", 32'(s_busy), 0);

      // four-cycle stall at count 10
      start = 1'b1;
      step();
      start = 1'b0;
      cyc = 0;
      repeat (10) begin step(); cyc++; end
      chk("stall_pre_count", 32'(s_count), 10);
      en = 1'b0;
      repeat (4) begin step(); cyc++; end
      chk("stall_hold_count", 32'(s_count), 10);
      chk("stall_hold_busy", 32'(s_busy), 1);
      en = 1'b1;
      while (!s_done && cyc < 100) begin step(); cyc++; end
      chk("stall_done_latency", cyc, 36);
      step();

      // restart at count 10
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (10) step();
      chk("restart_pre_count", 32'(s_count), 10);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("restart_count", 32'(s_count), 0);
      chk("restart_busy", 32'(s_busy), 1);
      cyc = 0;
      while (!s_done && cyc < 100) begin step(); cyc++; end
      chk("restart_done_latency", cyc, 32);
      step();

      // asynchronous clear between edges at count 17
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (17) step();
      chk("arst_pre_count", 32'(s_count), 17);
      #3 clr_n = 1'b0;
      #1;
      chk("arst_count", 32'(s_count), 0);
      chk("arst_busy", 32'(s_busy), 0);
      chk("arst_done", 32'(s_done), 0);
      chk("arst_tc", 32'(s_tc), 0);
      #1 clr_n = 1'b1;
      seen = 0;
      repeat (40) begin
         step();
         if (s_done || s_busy) seen++;
      end
      chk("arst_no_done", seen, 0);
      chk("arst_idle_count", 32'(s_count), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
